// File: rtl/dmem_bus_ctrl.sv
// ============================================================================
// Module   : dmem_bus_ctrl
// Brief    : Data-memory bus controller. It turns mem-stage accesses into
//            req/ack bus transactions and stalls the pipeline while each runs.
//            Optional DMEM_TIMEOUT_EN adds a BUSY timeout with a bus_err_o strobe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_bus_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_ce_i,
    input  logic                  mem_we_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [DATA_W/8-1:0]   mem_sel_i,
    input  logic [DATA_W-1:0]     mem_data_i,
    output logic [DATA_W-1:0]     mem_data_o,
    output logic                  stallreq_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [ADDR_W-1:0]     bus_addr_o,
    output logic [DATA_W/8-1:0]   bus_sel_o,
    output logic [DATA_W-1:0]     bus_wdata_o,
    input  logic                  bus_ack_i,
    input  logic [DATA_W-1:0]     bus_rdata_i,
    output logic                  bus_err_o
);

    localparam int SEL_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                timeout_w;

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q counts BUSY cycles already spent, so this fires in the last allowed one.
    assign timeout_w = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_w = (TIMEOUT_CYC < 0);
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
`ifdef DMEM_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (mem_ce_i) begin
                    we_d    = mem_we_i;
                    addr_d  = mem_addr_i;
                    sel_d   = mem_sel_i;
                    wdata_d = mem_data_i;
                    req_d   = 1'b1;
                    state_d = ST_BUSY;
`ifdef DMEM_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_BUSY: begin
                // Ack has priority over a coincident timeout.
                if (bus_ack_i) begin
                    if (!we_q) begin
                        rdata_d = bus_rdata_i;
                    end
                    req_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (timeout_w) begin
                    if (!we_q) begin
                        rdata_d = {DATA_W{1'b1}};
                    end
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = ST_DONE;
                end else begin
`ifdef DMEM_TIMEOUT_EN
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            sel_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef DMEM_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Gating with rst lets the stall drop the instant reset is applied, even with mem_ce_i held.
    assign stallreq_o  = !rst && (((state_q == ST_IDLE) && mem_ce_i) || (state_q == ST_BUSY));
    assign mem_data_o  = rdata_q;
    assign bus_req_o   = req_q;
    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_sel_o   = sel_q;
    assign bus_wdata_o = wdata_q;
    assign bus_err_o   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_bus_ctrl.sv
// ============================================================================
// Module   : tb_dmem_bus_ctrl
// Brief    : Randomized self-checking bench for dmem_bus_ctrl with a
//            transaction-level reference model and a behavioural bus slave.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dmem_bus_ctrl;

`ifdef DMEM_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_ce, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_sel;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stallreq;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_rdata;
    int          req_pulses = 0;
    logic        req_prev   = 1'b0;

    always #5 clk = ~clk;

    dmem_bus_ctrl #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_ce_i    (mem_ce),
        .mem_we_i    (mem_we),
        .mem_addr_i  (mem_addr),
        .mem_sel_i   (mem_sel),
        .mem_data_i  (mem_wdata),
        .mem_data_o  (mem_rdata),
        .stallreq_o  (stallreq),
        .bus_req_o   (bus_req),
        .bus_we_o    (bus_we),
        .bus_addr_o  (bus_addr),
        .bus_sel_o   (bus_sel),
        .bus_wdata_o (bus_wdata),
        .bus_ack_i   (bus_ack),
        .bus_rdata_i (bus_rdata),
        .bus_err_o   (bus_err)
    );

    // Request pulse counter, sampled away from the active edge.
    always @(negedge clk) begin
        req_prev <= bus_req;
        if (bus_req && !req_prev) begin
            req_pulses <= req_pulses + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete access. Entered and left 1ns after a rising edge with the DUT idle.
    // ack_dly = BUSY cycle (1-based) in which the slave acks; flush drops mem_ce in BUSY.
    task automatic run_access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                              input logic [31:0] wd, input int ack_dly, input logic [31:0] rd,
                              input logic flush, input logic full);
        int   stall_cnt;
        logic stable;
        mem_ce    = 1'b1;
        mem_we    = we;
        mem_addr  = addr;
        mem_sel   = sel;
        mem_wdata = wd;
        #1;
        stall_cnt = stallreq ? 1 : 0;
        tick();
        if (flush) mem_ce = 1'b0;
        if (full) begin
            check("busy_req", {31'd0, bus_req}, 32'd1);
            check("busy_we", {31'd0, bus_we}, {31'd0, we});
            check("busy_addr", bus_addr, addr);
            check("busy_sel", {28'd0, bus_sel}, {28'd0, sel});
            if (we) check("busy_wdata", bus_wdata, wd);
        end
        stable = 1'b1;
        for (int c = 1; c <= ack_dly; c++) begin
            if (!bus_req || bus_addr !== addr || bus_sel !== sel || bus_we !== we) stable = 1'b0;
            if (stallreq) stall_cnt++;
            if (c == ack_dly) begin
                bus_ack   = 1'b1;
                bus_rdata = rd;
            end
            tick();
            bus_ack   = 1'b0;
            bus_rdata = $urandom;
        end
        if (!we) exp_rdata = rd;
        check("bus_stable", {31'd0, stable}, 32'd1);
        check("stall_cycles", stall_cnt, ack_dly + 1);
        check("done_stall", {31'd0, stallreq}, 32'd0);
        check("done_req", {31'd0, bus_req}, 32'd0);
        check("done_rdata", mem_rdata, exp_rdata);
        if (full) check("done_err", {31'd0, bus_err}, 32'd0);
        tick();
        mem_ce = 1'b0;
    endtask

    initial begin
        int   pulses0;
        int   good;
        rst       = 1'b1;
        mem_ce    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_sel   = '0;
        mem_wdata = '0;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        exp_rdata = '0;
        tick();
        tick();
        check("rst_req", {31'd0, bus_req}, 32'd0);
        check("rst_stall", {31'd0, stallreq}, 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        check("rst_err", {31'd0, bus_err}, 32'd0);
        check("rst_addr", bus_addr, 32'd0);
        rst = 1'b0;
        tick();

        // Directed: minimum-latency read, sub-word write, back-to-back reads, flush.
        run_access(1'b0, 32'h0000_0010, 4'b1111, 32'h0, 1, 32'hDEAD_BEEF, 1'b0, 1'b1);
        run_access(1'b1, 32'h0000_0021, 4'b0100, 32'h5A5A_5A5A, 3, 32'h1111_2222, 1'b0, 1'b1);
        pulses0 = req_pulses;
        run_access(1'b0, 32'h0000_0100, 4'b1111, 32'h0, 1, 32'hA1A1_0100, 1'b0, 1'b1);
        run_access(1'b0, 32'h0000_0104, 4'b1111, 32'h0, 1, 32'hB2B2_0104, 1'b0, 1'b1);
        tick();
        check("b2b_pulses", req_pulses - pulses0, 32'd2);
        run_access(1'b0, 32'h0000_0300, 4'b0011, 32'h0, 5, 32'hC0FF_EE00, 1'b1, 1'b1);
        check("flush_idle_stall", {31'd0, stallreq}, 32'd0);
        run_access(1'b1, 32'h0000_0040, 4'b0000, 32'h1234_5678, 2, 32'h0, 1'b0, 1'b1);

        // Ack outside BUSY must be ignored.
        bus_ack   = 1'b1;
        bus_rdata = 32'h7777_7777;
        tick();
        bus_ack   = 1'b0;
        check("stray_ack_req", {31'd0, bus_req}, 32'd0);
        check("stray_ack_rdata", mem_rdata, exp_rdata);

        // Reset during BUSY, followed by a late ack.
        mem_ce   = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 32'h0000_0200;
        mem_sel  = 4'hF;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        exp_rdata = '0;
        check("arst_req", {31'd0, bus_req}, 32'd0);
        check("arst_stall", {31'd0, stallreq}, 32'd0);
        check("arst_addr", bus_addr, 32'd0);
        mem_ce    = 1'b0;
        bus_ack   = 1'b1;
        bus_rdata = 32'h5555_AAAA;
        tick();
        #2;
        rst = 1'b0;
        tick();
        bus_ack = 1'b0;
        check("late_ack_req", {31'd0, bus_req}, 32'd0);
        check("late_ack_stall", {31'd0, stallreq}, 32'd0);
        check("late_ack_rdata", mem_rdata, 32'd0);
        run_access(1'b0, 32'h0000_0204, 4'hF, 32'h0, 2, 32'h0BAD_F00D, 1'b0, 1'b1);

        // Randomized accesses against the model.
        for (int n = 0; n < 40; n++) begin
            run_access($urandom_range(0, 1) == 1, $urandom, 4'($urandom_range(0, 15)), $urandom,
                       $urandom_range(1, 6), $urandom, $urandom_range(0, 3) == 0,
                       (n % 4) == 0);
        end

`ifdef DMEM_TIMEOUT_EN
        // No ack: error strobe after TMO BUSY cycles, all-ones read data.
        mem_ce   = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 32'h0000_0400;
        mem_sel  = 4'hF;
        tick();
        good = 0;
        for (int c = 0; c < TMO; c++) begin
            if (stallreq && !bus_err) good++;
            tick();
        end
        check("tmo_busy_cycles", good, TMO);
        check("tmo_err", {31'd0, bus_err}, 32'd1);
        check("tmo_stall", {31'd0, stallreq}, 32'd0);
        check("tmo_rdata", mem_rdata, 32'hFFFF_FFFF);
        mem_ce = 1'b0;
        tick();
        check("tmo_err_pulse", {31'd0, bus_err}, 32'd0);
`else
        // No ack and no timeout: the stall is held for as long as we wait.
        mem_ce   = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 32'h0000_0400;
        mem_sel  = 4'hF;
        tick();
        good = 0;
        for (int c = 0; c < 300; c++) begin
            if (stallreq && bus_req && !bus_err) good++;
            tick();
        end
        check("hang_stall_held", good, 300);
        check("hang_rdata", mem_rdata, exp_rdata);
        mem_ce = 1'b0;
        rst    = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("hang_reset_req", {31'd0, bus_req}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
